// File: rtl/sys_defs.sv
// Shared definitions for the common data bus (CDB) logic.
//   XLEN       - datapath width of a broadcast result value
//   ROB_IDX_W  - width of a reorder-buffer tag
//   SRC_W      - width of a CDB source index
//   fu_src_e   - functional-unit source enumeration (CDB source index)
//   CDB_PACKET - one registered CDB broadcast {valid, rob_idx, value, src}
//   rr_index   - (base + offset) mod n, used by the round-robin scan
package sys_defs;

    localparam int XLEN      = 32;
    localparam int ROB_IDX_W = 5;
    localparam int SRC_W     = 3;

    typedef enum logic [SRC_W-1:0] {
        FU_ALU = 3'd0,
        FU_LD  = 3'd1,
        FU_ST  = 3'd2,
        FU_FP1 = 3'd3,
        FU_FP2 = 3'd4
    } fu_src_e;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [XLEN-1:0]      value;
        logic [SRC_W-1:0]     src;
    } CDB_PACKET;

    // Candidate source for a round-robin scan step; offset runs 1..n so that
    // the last granted source is considered last.
    function automatic logic [SRC_W-1:0] rr_index(input logic [SRC_W-1:0] base,
                                                  input int offset,
                                                  input int n);
        int s;
        s = (int'(base) + offset) % n;
        return SRC_W'(s);
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of the functional-unit result inputs and the CDB broadcast outputs.
//   fu_valid/fu_rob_idx/fu_value : per-source result offered by each FU
//   fu_ready                     : per-source "buffer can accept"
//   cdb_valid/cdb_rob_idx/cdb_value/cdb_src : registered CDB broadcast
// Handshake: source i transfers one result on the rising clock edge where
// fu_valid[i] && fu_ready[i]. fu_ready depends on registered state only, so a
// producer may sample it early in the cycle; a producer seeing fu_valid high
// with fu_ready low holds the same rob_idx/value until it is accepted.
// cdb_valid is a one-cycle strobe with no back-pressure from consumers.
// Modports: master = FUs plus CDB consumers, slave = the arbiter.
interface cdb_arbiter_if
    import sys_defs::*;
#(
    parameter int NUM_SRC = 5
);
    logic [NUM_SRC-1:0]                fu_valid;
    logic [NUM_SRC-1:0][ROB_IDX_W-1:0] fu_rob_idx;
    logic [NUM_SRC-1:0][XLEN-1:0]      fu_value;
    logic [NUM_SRC-1:0]                fu_ready;
    logic                              cdb_valid;
    logic [ROB_IDX_W-1:0]              cdb_rob_idx;
    logic [XLEN-1:0]                   cdb_value;
    logic [SRC_W-1:0]                  cdb_src;

    modport master (
        output fu_valid, fu_rob_idx, fu_value,
        input  fu_ready, cdb_valid, cdb_rob_idx, cdb_value, cdb_src
    );

    modport slave (
        input  fu_valid, fu_rob_idx, fu_value,
        output fu_ready, cdb_valid, cdb_rob_idx, cdb_value, cdb_src
    );
endinterface

// File: rtl/cdb_result_fifo.sv
// Per-source result buffer: DEPTH entries of {rob_idx, value}.
//   clock, reset_n (async, active-low), flush (sync squash)
//   push, push_rob_idx, push_value : offered result (accepted only when ready)
//   pop                            : remove head entry (ignored when empty)
//   ready                          : count < DEPTH, from registered count only
//   empty                          : count == 0
//   head_rob_idx, head_value       : oldest entry
// A full buffer stays not-ready even in a cycle where it is popped, so there
// is never an input-to-output pass-through.
module cdb_result_fifo
    import sys_defs::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 push,
    input  logic [ROB_IDX_W-1:0] push_rob_idx,
    input  logic [XLEN-1:0]      push_value,
    input  logic                 pop,
    output logic                 ready,
    output logic                 empty,
    output logic [ROB_IDX_W-1:0] head_rob_idx,
    output logic [XLEN-1:0]      head_value
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]     head_ptr;
    logic [PTR_W-1:0]     tail_ptr;
    logic [CNT_W-1:0]     count;
    logic [ROB_IDX_W-1:0] mem_rob [DEPTH];
    logic [XLEN-1:0]      mem_val [DEPTH];
    logic                 do_push;
    logic                 do_pop;

    assign ready        = (count < CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign do_push      = push && ready && !flush;
    assign do_pop       = pop && !empty && !flush;
    assign head_rob_idx = mem_rob[head_ptr];
    assign head_value   = mem_val[head_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (do_pop)  head_ptr <= head_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_rob[tail_ptr] <= push_rob_idx;
            mem_val[tail_ptr] <= push_value;
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers results from NUM_SRC functional units and
// broadcasts at most one per cycle, chosen round-robin.
//   clock   : sole clock
//   reset_n : asynchronous active-low reset
//   flush   : synchronous squash of all buffered and outgoing results
//   bus     : cdb_arbiter_if.slave (fu_* inputs, fu_ready, registered cdb_*)
// The scan starts at rr_ptr+1, rr_ptr holding the last granted source, so a
// non-empty source waits at most NUM_SRC cycles. rr_ptr resets to NUM_SRC-1
// so source 0 wins first. NUM_SRC must not exceed 8 (3-bit cdb_src).
module cdb_arbiter
    import sys_defs::*;
#(
    parameter int NUM_SRC    = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    logic [NUM_SRC-1:0]                fifo_ready;
    logic [NUM_SRC-1:0]                fifo_empty;
    logic [NUM_SRC-1:0]                pop;
    logic [NUM_SRC-1:0][ROB_IDX_W-1:0] head_rob;
    logic [NUM_SRC-1:0][XLEN-1:0]      head_val;
    logic [SRC_W-1:0]                  rr_ptr;
    logic [SRC_W-1:0]                  grant_idx;
    logic [SRC_W-1:0]                  cand;
    logic                              grant_valid;
    CDB_PACKET                         cdb_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        cdb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clock        (clock),
            .reset_n      (reset_n),
            .flush        (flush),
            .push         (bus.fu_valid[i]),
            .push_rob_idx (bus.fu_rob_idx[i]),
            .push_value   (bus.fu_value[i]),
            .pop          (pop[i]),
            .ready        (fifo_ready[i]),
            .empty        (fifo_empty[i]),
            .head_rob_idx (head_rob[i]),
            .head_value   (head_val[i])
        );
    end

    // First non-empty buffer after the last granted one, with wrap.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = rr_index(rr_ptr, k, NUM_SRC);
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant_valid && !flush) pop[grant_idx] = 1'b1;
    end

    // The popped head is captured at the same edge it leaves its buffer.
    // With nothing granted only valid drops; the data fields hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cdb_q  <= '0;
            rr_ptr <= SRC_W'(NUM_SRC - 1);
        end else if (flush) begin
            cdb_q.valid <= 1'b0;
        end else if (grant_valid) begin
            cdb_q <= '{valid:   1'b1,
                       rob_idx: head_rob[grant_idx],
                       value:   head_val[grant_idx],
                       src:     grant_idx};
            rr_ptr <= grant_idx;
        end else begin
            cdb_q.valid <= 1'b0;
        end
    end

    assign bus.fu_ready    = fifo_ready;
    assign bus.cdb_valid   = cdb_q.valid;
    assign bus.cdb_rob_idx = cdb_q.rob_idx;
    assign bus.cdb_value   = cdb_q.value;
    assign bus.cdb_src     = cdb_q.src;
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: NUM_SRC, default 5, number of FU result sources, indexed 0=ALU, 1=LD, 2=ST, 3=FP1, 4=FP2.
REQ-002 Parameter: FIFO_DEPTH, default 2, result-buffer entries per source (power of two, >=2).
REQ-003 Port: clock  input  1  sole clock; all state updates on posedge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: flush  input  1  synchronous squash of all buffered and outgoing results.
REQ-006 Port: fu_valid  input  NUM_SRC  per-source result valid.
REQ-007 Port: fu_rob_idx  input  NUM_SRC x 5  per-source ROB tag of the result.
REQ-008 Port: fu_value  input  NUM_SRC x XLEN  per-source result value.
REQ-009 Port: fu_ready  output  NUM_SRC  per-source buffer can accept.
REQ-010 Port: cdb_valid  output  1  broadcast valid, registered.
REQ-011 Port: cdb_rob_idx  output  5  broadcast ROB tag, registered.
REQ-012 Port: cdb_value  output  XLEN  broadcast value, registered.
REQ-013 Port: cdb_src  output  3  index of granted source, registered.

Function
REQ-014 Each source SHALL own a FIFO of FIFO_DEPTH {rob_idx, value} entries with head/tail pointers wrapping modulo FIFO_DEPTH and a count of width clog2(FIFO_DEPTH)+1.
REQ-015 fu_ready[i] SHALL be asserted iff count[i] < FIFO_DEPTH, derived from registered state only, with no combinational path from fu_valid or from grant.
REQ-016 A push into FIFO i SHALL occur on a clock edge where fu_valid[i] && fu_ready[i]; fu_valid with fu_ready low SHALL be ignored, and the source holds its data.
REQ-017 A full FIFO SHALL stay not-ready in a cycle where it is also popped; no pass-through.
REQ-018 Each cycle, the grant SHALL go to the first non-empty FIFO scanning from (rr_ptr+1) mod NUM_SRC upward with wrap; on grant, rr_ptr <= granted index.
REQ-019 On grant, the head entry SHALL be popped and loaded into the cdb_* registers with cdb_valid=1 at the same edge; with no non-empty FIFO, cdb_valid <= 0 and the data registers hold.
REQ-020 Latency: a result accepted at edge E SHALL appear on the CDB no earlier than the cycle following edge E+1; there is no input-to-CDB bypass.
REQ-021 At most one result SHALL be broadcast per cycle; per-source order SHALL be FIFO.
REQ-022 Simultaneous push and pop on one FIFO SHALL leave count unchanged and update both pointers.
REQ-023 flush SHALL, at the next edge, empty all FIFOs, clear cdb_valid, and discard any same-cycle push and grant; rr_ptr is unchanged.
REQ-024 Starvation bound: a non-empty source SHALL be granted within NUM_SRC cycles.

Reset
REQ-025 On reset_n low, all FIFOs SHALL empty immediately with pointers at 0, and cdb_valid=0, cdb_rob_idx=0, cdb_value=0, cdb_src=0, rr_ptr=NUM_SRC-1, so that source 0 wins first.
REQ-026 fu_ready SHALL be all-ones while reset_n is low and after release.
REQ-027 Reset asserted mid-operation SHALL drop all pending results with no partial broadcast.

Structure
REQ-028 XLEN, the ROB tag width (5), the FU source enumeration (ALU, LD, ST, FP1, FP2) and the CDB_PACKET struct {valid, rob_idx, value, src} SHALL live in the shared sys_defs package.
REQ-029 The per-source buffer SHALL be one sub-module, cdb_result_fifo, instantiated NUM_SRC times; arbitration and output registers stay in cdb_arbiter.

Verification
REQ-030 Single result: ALU pushes tag 3, value 0x0000_00AA at edge 1 -> cdb_valid=1, rob_idx=3, value 0xAA, src=0 after edge 2; cdb_valid=0 after edge 3.
REQ-031 All-contend: all five sources push tags 1..5 at the same edge, fresh after reset -> five consecutive broadcasts with src 0,1,2,3,4 and no gaps.
REQ-032 Backpressure: LD pushes 3 results, tags 7, 8, 9, on back-to-back edges while ALU is held continuously non-empty -> fu_ready[1]=0 once count=2; the third result is accepted only after the first pop; LD broadcasts in order 7, 8, 9 with no loss.
REQ-033 Wrap/fairness: FIFO_DEPTH=2, sources 0 and 3 continuously fed for 20 cycles -> grants strictly alternate 0, 3, 0, 3; pointers wrap with no corruption.
REQ-034 Flush: flush=1 with 2 entries buffered and cdb_valid=1 -> next cycle cdb_valid=0, all fu_ready=1, and the flushed tags never appear.
REQ-035 Async reset: reset_n pulsed low between edges while entries are buffered -> outputs clear immediately, before the next edge, and resume per REQ-025.
